// File: rtl/mul_iter.sv
// Iterative 32x32->64 multiplier for the execute stage (MUL/MULH/MULHSU/MULHU).
// Retires STEP multiplier bits per RUN cycle; operands and signs are latched on acceptance.
//
// state | meaning
// IDLE  | waiting for go; done=0
// RUN   | accumulating partial products, busy=1
// DONE  | result valid, held until advance or go drops
module mul_iter #(
  parameter int STEP = 4
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        go,
  input  logic        advance,
  input  logic        sign0,
  input  logic        sign1,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic        done,
  output logic [63:0] result,
  output logic        busy
);

  localparam int NCHUNK = 32 / STEP;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST  = CW'(NCHUNK - 1);
  localparam logic [5:0]    STEP6 = 6'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [63:0]     m_ext;
  logic [31:0]     r_q;
  logic            sign0_q;
  logic [63:0]     acc;
  logic [CW-1:0]   count;
  logic            last;
  logic [5:0]      bit_pos;
  logic [STEP-1:0] chunk;
  logic [63:0]     partial;
  logic [63:0]     corr;
  logic [63:0]     acc_nxt;

  assign last    = (count == LAST);
  assign bit_pos = 6'(count) * STEP6;
  assign chunk   = r_q[bit_pos +: STEP];
  assign partial = (m_ext * 64'(chunk)) << bit_pos;
  // r is accumulated as unsigned; a negative signed r needs -(m_ext * 2^32) once.
  assign corr    = (last && sign0_q && r_q[31]) ? {m_ext[31:0], 32'd0} : 64'd0;
  assign acc_nxt = acc + partial - corr;

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go) state_nxt = S_RUN;
      S_RUN: begin
        if (!go)       state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE: if (advance || !go) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      m_ext   <= 64'd0;
      r_q     <= 32'd0;
      sign0_q <= 1'b0;
      acc     <= 64'd0;
      count   <= '0;
      result  <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            m_ext   <= sign1 ? {{32{m[31]}}, m} : {32'd0, m};
            r_q     <= r;
            sign0_q <= sign0;
            acc     <= 64'd0;
            count   <= '0;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (go && last) result <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: cycle-level behavioural model plus directed literal cases
// and randomized operations (aborts, holds, operand changes mid-run).
module tb_mul_iter;

  localparam int STEP = 4;
  localparam int LAT  = 1 + 32 / STEP;

  logic        clk_core = 1'b0;
  logic        reset    = 1'b1;
  logic        go       = 1'b0;
  logic        advance  = 1'b0;
  logic        sign0    = 1'b0;
  logic        sign1    = 1'b0;
  logic [31:0] m        = 32'd0;
  logic [31:0] r        = 32'd0;
  logic        done;
  logic        busy;
  logic [63:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_core = ~clk_core;

  mul_iter #(.STEP(STEP)) dut (
    .clk_core (clk_core),
    .reset    (reset),
    .go       (go),
    .advance  (advance),
    .sign0    (sign0),
    .sign1    (sign1),
    .m        (m),
    .r        (r),
    .done     (done),
    .result   (result),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain 64-bit product of the extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
    logic [63:0] x;
    logic [63:0] y;
    x = sa ? {{32{a[31]}}, a} : {32'd0, a};
    y = sb ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  // Behavioural model: an op is a countdown of cycles to completion.
  bit          md_busy = 0;
  bit          md_done = 0;
  int          md_left = 0;
  logic [63:0] md_prod = 64'd0;
  logic [63:0] md_res  = 64'd0;

  always @(posedge clk_core or posedge reset) begin
    if (reset) begin
      md_busy = 0; md_done = 0; md_left = 0; md_prod = 64'd0; md_res = 64'd0;
    end else if (md_done) begin
      if (advance || !go) md_done = 0;
    end else if (md_busy) begin
      if (!go) md_busy = 0;
      else begin
        md_left--;
        if (md_left == 0) begin
          md_busy = 0; md_done = 1; md_res = md_prod;
        end
      end
    end else if (go) begin
      md_busy = 1;
      md_left = 32 / STEP;
      md_prod = ref_prod(m, r, sign1, sign0);
    end
  end

  always @(negedge clk_core) begin
    chk("busy", {63'd0, busy}, {63'd0, md_busy});
    chk("done", {63'd0, done}, {63'd0, md_done});
    if (md_done || reset) chk("result", result, md_res);
  end

  task automatic tick();
    @(posedge clk_core);
    #2;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s0, input logic s1,
                        input logic [63:0] exp, input string name, input bit scramble);
    int k;
    go = 1'b1; m = a; r = b; sign0 = s0; sign1 = s1; advance = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
      if (scramble && k == 3) begin
        m = ~a; r = $urandom; sign0 = ~s0; sign1 = ~s1;
      end
    end
    chk({name, "_latency"}, 64'(k), 64'(LAT));
    chk(name, result, exp);
  endtask

  task automatic release_op();
    advance = 1'b1;
    tick();
    advance = 1'b0;
    go = 1'b0;
    chk("done_fall", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int          k;
    int          low;
    int          abort_at;
    logic [31:0] a, b;
    logic        s0, s1;
    logic [63:0] exp;
    logic [63:0] held;

    repeat (2) @(posedge clk_core);
    #2 reset = 1'b0;
    chk("reset_result", result, 64'd0);
    tick();

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, "umul", 1'b0);
    release_op();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, "smul_m1", 1'b0);
    release_op();
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, "smul_min", 1'b0);
    release_op();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001, "mulhsu", 1'b0);
    release_op();

    // Hold in DONE with operands scrambled mid-run.
    exp = ref_prod(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, exp, "scramble", 1'b1);
    held = result;
    repeat (5) begin
      tick();
      chk("hold_done", {63'd0, done}, 64'd1);
      chk("hold_result", result, held);
    end
    release_op();

    // Abort at RUN cycle 3.
    go = 1'b1; m = 32'd11; r = 32'd13; sign0 = 1'b0; sign1 = 1'b0;
    repeat (3) tick();
    go = 1'b0;
    low = 0;
    repeat (12) begin
      tick();
      if (done) low++;
    end
    chk("abort_no_done", 64'(low), 64'd0);
    run_op(32'd6, 32'd7, 1'b0, 1'b0, 64'd42, "after_abort", 1'b0);
    release_op();

    // Reset mid-run clears outputs without a clock edge.
    go = 1'b1; m = 32'hDEAD_BEEF; r = 32'h0BAD_F00D;
    repeat (4) tick();
    #1 reset = 1'b1;
    #1;
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", result, 64'd0);
    go = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back: advance with go held high starts the next op.
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 64'd15, "b2b_first", 1'b0);
    advance = 1'b1; m = 32'd7; r = 32'd9;
    tick();
    advance = 1'b0;
    low = 0;
    while (!done && low < 40) begin
      low++;
      tick();
    end
    chk("b2b_gap", 64'(low), 64'(LAT));
    chk("b2b_result", result, 64'd63);
    release_op();

    // Randomized operations.
    repeat (150) begin
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      exp = ref_prod(a, b, s1, s0);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      go = 1'b1; m = a; r = b; sign0 = s0; sign1 = s1; advance = 1'b0;
      k = 0;
      while (!done && k < 40) begin
        tick();
        k++;
        advance = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          m = $urandom; r = $urandom;
          sign0 = 1'($urandom_range(0, 1)); sign1 = 1'($urandom_range(0, 1));
        end
        if (k == abort_at) break;
      end
      if (abort_at != 0) begin
        go = 1'b0; advance = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end else begin
        chk("rand_latency", 64'(k), 64'(LAT));
        chk("rand_result", result, exp);
        if (!advance) begin
          repeat ($urandom_range(0, 3)) tick();
        end
        if ($urandom_range(0, 1) == 1) advance = 1'b1;
        else go = 1'b0;
        tick();
        advance = 1'b0; go = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
